// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch enable generator: FSM state encoding.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: multi-flop synchronizer, stable-sample debouncer and a
// registered one-cycle pulse on each accepted 0->1 level change.
module btn_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 50000,
    parameter int unsigned DB_W        = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   db_level;
    logic [DB_W-1:0]        db_cnt;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Shift the raw button through the synchronizer chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing samples;
    // any bounce back to the current level restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_level    <= 1'b0;
            db_cnt      <= '0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (sync_out == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level    <= sync_out;
                db_cnt      <= '0;
                press_pulse <= sync_out;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_enable_gen.sv
// Stopwatch enable generator: debounced start/stop button drives an
// IDLE/RUN/PAUSE FSM; a prescaler emits count_enb ticks while running.
// Optional macro CLEAR_BTN_EN adds a clear button (PAUSE -> IDLE) and the
// counter_clr output.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_IDLE  | stopped, prescaler held at 0
//   ST_RUN   | ticking at clk/(presc_div+1)
//   ST_PAUSE | stopped, prescaler phase held for resume
//   ST_UNUSED| illegal, recovers to ST_IDLE
module stopwatch_enable_gen
    import stopwatch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 50000,
    parameter int unsigned DB_W        = 16,
    parameter int unsigned PRESC_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_start_raw,
`ifdef CLEAR_BTN_EN
    input  logic               btn_clear_raw,
    output logic               counter_clr,
`endif
    input  logic [PRESC_W-1:0] presc_div,
    output logic               count_enb,
    output logic               running,
    output logic [1:0]         fsm_state,
    output logic               press_pulse
);

    state_t             state;
    logic [PRESC_W-1:0] presc_cnt;
    logic               start_pulse;

    btn_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES),
        .DB_W        (DB_W)
    ) u_start_db (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_start_raw),
        .press_pulse (start_pulse)
    );

    assign press_pulse = start_pulse;
    assign fsm_state   = state;

`ifdef CLEAR_BTN_EN
    logic clear_pulse;

    btn_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES),
        .DB_W        (DB_W)
    ) u_clear_db (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_clear_raw),
        .press_pulse (clear_pulse)
    );
`endif

    // Run/pause FSM advanced by accepted presses; running mirrors ST_RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            running <= 1'b0;
`ifdef CLEAR_BTN_EN
            counter_clr <= 1'b0;
`endif
        end else begin
`ifdef CLEAR_BTN_EN
            counter_clr <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start_pulse) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (start_pulse) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end
                end
                ST_PAUSE: begin
`ifdef CLEAR_BTN_EN
                    if (clear_pulse) begin
                        state       <= ST_IDLE;
                        running     <= 1'b0;
                        counter_clr <= 1'b1;
                    end else
`endif
                    if (start_pulse) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Prescaler acts on the current state, so a press on a tick edge still
    // lets that tick through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt <= '0;
            count_enb <= 1'b0;
        end else begin
            count_enb <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (presc_cnt >= presc_div) begin
                        presc_cnt <= '0;
                        count_enb <= 1'b1;
                    end else begin
                        presc_cnt <= presc_cnt + PRESC_W'(1);
                    end
                end
                ST_PAUSE: begin
`ifdef CLEAR_BTN_EN
                    if (clear_pulse) begin
                        presc_cnt <= '0;
                    end
`endif
                end
                default: begin
                    presc_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_enable_gen.sv
// Bench for stopwatch_enable_gen with short debounce (DB_CYCLES=4).
module tb_stopwatch_enable_gen;

    localparam int SS  = 2;
    localparam int DB  = 4;
    localparam int DBW = 3;
    localparam int PW  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          btn = 1'b0;
    logic [PW-1:0] presc_div = 16'd3;
    logic          count_enb;
    logic          running;
    logic [1:0]    fsm_state;
    logic          press_pulse;
`ifdef CLEAR_BTN_EN
    logic          btn_clear_raw = 1'b0;
    logic          counter_clr;
`endif

    stopwatch_enable_gen #(
        .SYNC_STAGES (SS),
        .DB_CYCLES   (DB),
        .DB_W        (DBW),
        .PRESC_W     (PW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_start_raw (btn),
`ifdef CLEAR_BTN_EN
        .btn_clear_raw (btn_clear_raw),
        .counter_clr   (counter_clr),
`endif
        .presc_div     (presc_div),
        .count_enb     (count_enb),
        .running       (running),
        .fsm_state     (fsm_state),
        .press_pulse   (press_pulse)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: delay line for synchronization, run-length of
    // samples disagreeing with the accepted level, cycles-since-tick phase.
    bit m_sync [SS];
    bit m_lvl   = 1'b0;
    bit m_pulse = 1'b0;
    bit m_enb   = 1'b0;
    int m_run   = 0;
    int m_since = 0;
    int m_state = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
            m_lvl = 0; m_pulse = 0; m_enb = 0; m_run = 0; m_since = 0; m_state = 0;
        end else begin
            m_enb = 1'b0;
            if (m_state == 1) begin
                m_since++;
                if (m_since >= int'(presc_div) + 1) begin
                    m_enb   = 1'b1;
                    m_since = 0;
                end
            end else if (m_state == 0) begin
                m_since = 0;
            end
            if (m_pulse) m_state = (m_state == 1) ? 2 : 1;
            m_pulse = 1'b0;
            if (m_sync[SS-1] != m_lvl) begin
                m_run++;
                if (m_run == DB) begin
                    m_lvl   = m_sync[SS-1];
                    m_run   = 0;
                    m_pulse = m_lvl;
                end
            end else begin
                m_run = 0;
            end
            for (int i = SS-1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = btn;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    int pulse_cnt = 0;
    int enb_cnt   = 0;
    always @(negedge clk) begin
        chk("count_enb", int'(count_enb), int'(m_enb));
        chk("running", int'(running), (m_state == 1) ? 1 : 0);
        chk("fsm_state", int'(fsm_state), m_state);
        chk("press_pulse", int'(press_pulse), int'(m_pulse));
        if (press_pulse) pulse_cnt++;
        if (count_enb) enb_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int  k, tc, dbl, pt, ones;
    bit  found, prev;
    logic [5:0] pat;

    initial begin
        #1 reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;

        // Idle after reset
        repeat (20) step();
        chk("idle_pulses", pulse_cnt, 0);
        chk("idle_ticks", enb_cnt, 0);
        chk("idle_state", int'(fsm_state), 0);
        chk("idle_running", int'(running), 0);

        // Bouncing press 1,0,1 then hold
        btn = 1'b1; step();
        btn = 1'b0; step();
        btn = 1'b1;
        k = 0; found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            step();
            if (press_pulse) begin k = i; found = 1; end
        end
        chk("press_latency", k, 6);
        step();
        chk("state_after_press", int'(fsm_state), 1);
        chk("pulses_after_bounce", pulse_cnt, 1);

        // presc_div=3: four single-cycle ticks in 16 cycles
        tc = 0; dbl = 0; prev = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (count_enb) tc++;
            if (count_enb && prev) dbl++;
            prev = count_enb;
        end
        chk("ticks_in_16", tc, 4);
        chk("tick_width", dbl, 0);

        // Release, then align a press so the held phase count is 2
        btn = 1'b0;
        repeat (10) step();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (count_enb) found = 1;
        end
        chk("tick_seen_before_pause", int'(found), 1);
        repeat (3) step();
        btn = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (fsm_state == 2'd2) found = 1;
        end
        chk("entered_pause", int'(found), 1);
        chk("model_phase_at_pause", m_since, 2);
        btn = 1'b0;
        pt = 0;
        repeat (10) begin
            step();
            if (count_enb) pt++;
        end
        btn = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (fsm_state == 2'd1) found = 1;
            else if (count_enb) pt++;
        end
        chk("resumed", int'(found), 1);
        chk("pause_ticks", pt, 0);
        k = 0; found = 0;
        for (int i = 1; i <= 10 && !found; i++) begin
            step();
            if (count_enb) begin k = i; found = 1; end
        end
        chk("resume_first_tick", k, 2);

        // presc_div=0: tick every cycle
        btn = 1'b0;
        presc_div = 16'd0;
        ones = 0;
        repeat (5) begin
            step();
            if (count_enb) ones++;
        end
        chk("div0_ticks", ones, 5);

        // Drop presc_div 9 -> 1 while the phase count is 5
        presc_div = 16'd9;
        repeat (5) step();
        presc_div = 16'd1;
        pat = '0;
        repeat (6) begin
            step();
            pat = {pat[4:0], count_enb};
        end
        chk("div_drop_pattern", int'(pat), 6'b101010);

        // Asynchronous reset mid-run
        #2 reset = 1'b0;
        #1;
        chk("rst_count_enb", int'(count_enb), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_fsm_state", int'(fsm_state), 0);
        chk("rst_press_pulse", int'(press_pulse), 0);
        step();
        reset = 1'b1;
        repeat (5) step();
        chk("post_reset_state", int'(fsm_state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_enable_gen.md
Name: stopwatch_enable_gen

Overview:
- Upstream control stage that generates the count_enb pulse train for the N-bit enable counter.
- Debounces a raw start/stop push-button and runs a 3-state IDLE/RUN/PAUSE FSM.
- While in RUN, a programmable prescaler emits one-cycle enable ticks, so the downstream counter advances at clk/(presc_div+1).

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth on each raw button input; minimum 2.
- DB_CYCLES, 50000, number of consecutive stable synchronized samples needed to accept a button level change; minimum 2.
- DB_W, 16, debounce counter width; must satisfy 2^DB_W > DB_CYCLES.
- PRESC_W, 16, prescaler counter and divisor width.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset.
- btn_start_raw  input  1  raw, unsynchronized, bouncing button; active-high.
- presc_div  input  PRESC_W  tick period minus 1; sampled every cycle.
- count_enb  output  1  registered one-cycle tick; drives the counter enable.
- running  output  1  registered; high while the FSM is in RUN.
- fsm_state  output  2  registered state code (IDLE=0, RUN=1, PAUSE=2).
- press_pulse  output  1  registered one-cycle pulse on each accepted start press.

Behaviour:
- Reset (reset=0, asynchronous): all synchronizer flops, debounce level, debounce counter and prescaler counter clear to 0; FSM goes to IDLE; count_enb, running and press_pulse are 0; fsm_state=0. Reset asserted mid-operation aborts immediately with the same values.
- Synchronizer: SYNC_STAGES flops in series; sync_out is the last stage.
- Debounce counter:
  - If sync_out equals db_level, db_cnt is cleared to 0.
  - Otherwise db_cnt increments. On the edge where db_cnt==DB_CYCLES-1, db_level takes sync_out and db_cnt returns to 0.
  - Any bounce back to db_level before that edge restarts the count.
- press_pulse is set to 1 on exactly the edge where db_level changes 0->1, and is 0 otherwise. Release (1->0) produces no pulse.
- Latency: a clean raw rise setting up before edge 1 gives press_pulse=1 after edge SYNC_STAGES+DB_CYCLES, for exactly one cycle.
- FSM transitions, evaluated on the edge after press_pulse is seen high:
  - IDLE->RUN.
  - RUN->PAUSE.
  - PAUSE->RUN.
  - No other transitions exist. The unused code 3 goes to IDLE.
- Prescaler, on each edge while the current state is RUN:
  - If presc_cnt >= presc_div: presc_cnt<=0 and count_enb<=1.
  - Otherwise: presc_cnt<=presc_cnt+1 and count_enb<=0.
- Prescaler in other states:
  - PAUSE: presc_cnt holds its value (phase is kept on resume) and count_enb<=0.
  - IDLE: presc_cnt<=0 and count_enb<=0.
- Tick period is presc_div+1 cycles. presc_div=0 gives count_enb=1 on every cycle in RUN.
- Lowering presc_div below the current presc_cnt mid-run gives a tick on the next edge, then the new period.
- Simultaneous press and tick on one edge: the prescaler acts on the current state; the FSM moves on that same edge.
- running and fsm_state are registered copies of the state.

Optional Feature:
- Macro CLEAR_BTN_EN.
- When defined, two extra ports are added: btn_clear_raw (input, 1) and counter_clr (output, 1, registered).
  - btn_clear_raw gets its own synchronizer and debouncer.
  - A clear press while in PAUSE moves the FSM to IDLE, clears presc_cnt, and pulses counter_clr for one cycle, coincident with the entry to IDLE.
  - A clear press in RUN or IDLE is ignored.
  - If start and clear presses land on the same edge in PAUSE, clear wins.
- When not defined, the ports are absent and PAUSE is left only by a start press.

Decomposition:
- Package stopwatch_pkg holds the FSM state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2) and the state typedef.
- Sub-module btn_debounce (synchronizer + debounce counter + rise pulse) with parameters SYNC_STAGES, DB_CYCLES and DB_W. It is instantiated once, or twice when CLEAR_BTN_EN is defined.

Test Plan (DB_CYCLES=4, SYNC_STAGES=2):
- Reset, then idle for 20 cycles -> count_enb=0, running=0, fsm_state=0, press_pulse never high.
- btn_start_raw bounces 1,0,1 (1 cycle each), then holds 1 -> exactly one press_pulse, 6 edges after the final stable rise; fsm_state=1 on the next edge.
- RUN with presc_div=3 for 16 cycles -> count_enb high on every 4th cycle (4 pulses), each exactly 1 cycle wide.
- Press in RUN while presc_cnt=2, wait 10 cycles, press again -> no ticks in PAUSE; the first tick after resume comes 2 cycles after re-entering RUN.
- presc_div=0 in RUN -> count_enb high every cycle. Drop presc_div from 9 to 1 while presc_cnt=5 -> tick on the next edge, then a period of 2.
- Assert reset for 1 cycle mid-RUN -> all outputs 0 immediately. With CLEAR_BTN_EN, a clear press in PAUSE -> counter_clr pulses once and fsm_state=0.
